mem_arbiter2: RTL and testbench

MEM_ARBITER2 -- requirements
Module: mem_arbiter2

---
 rtl/mem_arbiter2.sv | 127 ++++++++++++
 tb/tb_mem_arbiter2.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter2.sv
// Two-master arbiter onto a single memory/peripheral slave (round-robin or fixed priority).
// Latency: grant registered on the IDLE edge, ready pulses the cycle after s_ready; masters hold valid until ready.
module mem_arbiter2 #(
  parameter int TIMEOUT    = 255,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam bit          TO_EN  = (TIMEOUT > 0);
  localparam int unsigned TERM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [7:0]  TERM   = TERM_I[7:0];

  state_t     state, state_nxt;
  logic       last_grant;
  logic [7:0] cnt;
  logic       winner;
  logic       take;
  logic       complete;
  logic       expire;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    winner    = m1_valid;
    take      = 1'b0;
    complete  = 1'b0;
    expire    = 1'b0;
    if (m0_valid && m1_valid)
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          take      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A real response on the terminal-count cycle beats the timeout.
        if (s_ready && s_valid) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (TO_EN && cnt == TERM) begin
          expire    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid     <= 1'b0;
      s_addr      <= 32'd0;
      s_wdata     <= 32'd0;
      s_wstrb     <= 4'd0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_rdata    <= 32'd0;
      m1_rdata    <= 32'd0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      timeout_err <= 1'b0;
      cnt         <= 8'd0;
    end else begin
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      timeout_err <= 1'b0;
      if (take) begin
        s_valid    <= 1'b1;
        s_addr     <= winner ? m1_addr  : m0_addr;
        s_wdata    <= winner ? m1_wdata : m0_wdata;
        s_wstrb    <= winner ? m1_wstrb : m0_wstrb;
        grant      <= winner;
        last_grant <= winner;
        cnt        <= 8'd0;
      end
      // Saturate so a disabled timeout never wraps back to a small count.
      if (state == BUSY && !complete && !expire && cnt != 8'hFF)
        cnt <= cnt + 8'd1;
      if (complete || expire) begin
        s_valid     <= 1'b0;
        timeout_err <= expire;
        if (grant) begin
          m1_ready <= 1'b1;
          m1_rdata <= complete ? s_rdata : 32'hDEAD_BEEF;
        end else begin
          m0_ready <= 1'b1;
          m0_rdata <= complete ? s_rdata : 32'hDEAD_BEEF;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench: instance 0 is round-robin, instance 1 fixed priority; both TIMEOUT=8, shared stimulus.
module tb_mem_arbiter2;

  localparam logic [31:0] M0_WDATA = 32'h0BAD_F00D;
  localparam logic [31:0] M1_WDATA = 32'hFACE_0001;
  localparam logic [3:0]  M1_WSTRB = 4'h3;

  logic        clk;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr;
  logic [3:0]  m0_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  logic [1:0]  m0_ready, m1_ready, s_valid, grant, busy, timeout_err;
  logic [31:0] m0_rdata [2];
  logic [31:0] m1_rdata [2];
  logic [31:0] s_addr   [2];
  logic [31:0] s_wdata  [2];
  logic [3:0]  s_wstrb  [2];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter2 #(.TIMEOUT(8), .FIXED_PRIO(g)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(M0_WDATA), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready[g]), .m0_rdata(m0_rdata[g]),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(M1_WDATA), .m1_wstrb(M1_WSTRB),
      .m1_ready(m1_ready[g]), .m1_rdata(m1_rdata[g]),
      .s_valid(s_valid[g]), .s_addr(s_addr[g]), .s_wdata(s_wdata[g]), .s_wstrb(s_wstrb[g]),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant[g]), .busy(busy[g]), .timeout_err(timeout_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v0, v1; logic [31:0] a0, a1; logic [3:0] w0; logic sr; logic [31:0] srd;
    logic e_sv; logic [31:0] e_sa; logic [3:0] e_sw; logic e_g, e_busy, e_r0, e_r1;
    logic [31:0] e_d0, e_d1; logic e_to;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1,1,32'h100,32'h200,0,0,0,            1,32'h100,0,0,1,0,0,0,0,0};
    vecs[1]  = '{1,1,32'h100,32'h200,0,1,32'hA0A00001, 0,32'h100,0,0,1,1,0,32'hA0A00001,0,0};
    vecs[2]  = '{0,1,32'h100,32'h200,0,0,0,            0,32'h100,0,0,0,0,0,32'hA0A00001,0,0};
    vecs[3]  = '{0,1,32'h100,32'h200,0,0,0,            1,32'h200,3,1,1,0,0,32'hA0A00001,0,0};
    vecs[4]  = '{0,1,32'h100,32'h200,0,0,0,            1,32'h200,3,1,1,0,0,32'hA0A00001,0,0};
    vecs[5]  = '{0,1,32'h100,32'h200,0,1,32'hB0B00002, 0,32'h200,3,1,1,0,1,32'hA0A00001,32'hB0B00002,0};
    vecs[6]  = '{0,0,32'h100,32'h200,0,0,0,            0,32'h200,3,1,0,0,0,32'hA0A00001,32'hB0B00002,0};
    vecs[7]  = '{1,1,32'h104,32'h204,0,0,0,            1,32'h104,0,0,1,0,0,32'hA0A00001,32'hB0B00002,0};
    vecs[8]  = '{1,1,32'h104,32'h204,0,1,32'hC0C00003, 0,32'h104,0,0,1,1,0,32'hC0C00003,32'hB0B00002,0};
    vecs[9]  = '{0,1,32'h104,32'h204,0,0,0,            0,32'h104,0,0,0,0,0,32'hC0C00003,32'hB0B00002,0};
    vecs[10] = '{0,1,32'h104,32'h204,0,0,0,            1,32'h204,3,1,1,0,0,32'hC0C00003,32'hB0B00002,0};
    vecs[11] = '{0,1,32'h104,32'h204,0,1,32'hD0D00004, 0,32'h204,3,1,1,0,1,32'hC0C00003,32'hD0D00004,0};
    vecs[12] = '{0,0,32'h104,32'h204,0,0,0,            0,32'h204,3,1,0,0,0,32'hC0C00003,32'hD0D00004,0};
    vecs[13] = '{1,0,32'h10,0,0,0,0,                   1,32'h10,0,0,1,0,0,32'hC0C00003,32'hD0D00004,0};
    vecs[14] = '{1,0,32'h10,0,0,1,32'h12345678,        0,32'h10,0,0,1,1,0,32'h12345678,32'hD0D00004,0};
    vecs[15] = '{0,0,32'h10,0,0,0,0,                   0,32'h10,0,0,0,0,0,32'h12345678,32'hD0D00004,0};
    vecs[16] = '{1,0,32'h20,0,4'hF,0,0,                1,32'h20,4'hF,0,1,0,0,32'h12345678,32'hD0D00004,0};
    vecs[17] = '{1,0,32'h20,0,4'hF,1,32'h5555AAAA,     0,32'h20,4'hF,0,1,1,0,32'h5555AAAA,32'hD0D00004,0};
    vecs[18] = '{0,0,32'h20,0,4'hF,0,0,                0,32'h20,4'hF,0,0,0,0,32'h5555AAAA,32'hD0D00004,0};
    vecs[19] = '{0,0,32'h20,0,4'hF,1,32'hFFFFFFFF,     0,32'h20,4'hF,0,0,0,0,32'h5555AAAA,32'hD0D00004,0};

    reset = 1'b1; m0_valid = 0; m1_valid = 0; m0_addr = 0; m1_addr = 0;
    m0_wstrb = 0; s_ready = 0; s_rdata = 0;
    step();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d s_valid", d), {31'd0, s_valid[d]}, 0);
      check($sformatf("rst%0d s_addr", d), s_addr[d], 0);
      check($sformatf("rst%0d s_wdata", d), s_wdata[d], 0);
      check($sformatf("rst%0d s_wstrb", d), {28'd0, s_wstrb[d]}, 0);
      check($sformatf("rst%0d readys", d), {30'd0, m1_ready[d], m0_ready[d]}, 0);
      check($sformatf("rst%0d rdata0", d), m0_rdata[d], 0);
      check($sformatf("rst%0d rdata1", d), m1_rdata[d], 0);
      check($sformatf("rst%0d grant/busy/to", d), {29'd0, grant[d], busy[d], timeout_err[d]}, 0);
    end
    reset = 1'b0;

    // Cycle-by-cycle table against the round-robin instance
    for (int i = 0; i < 20; i++) begin
      m0_valid = vecs[i].v0; m1_valid = vecs[i].v1;
      m0_addr = vecs[i].a0; m1_addr = vecs[i].a1; m0_wstrb = vecs[i].w0;
      s_ready = vecs[i].sr; s_rdata = vecs[i].srd;
      step();
      check($sformatf("vec%0d s_valid", i), {31'd0, s_valid[0]}, {31'd0, vecs[i].e_sv});
      check($sformatf("vec%0d s_addr", i), s_addr[0], vecs[i].e_sa);
      check($sformatf("vec%0d s_wstrb", i), {28'd0, s_wstrb[0]}, {28'd0, vecs[i].e_sw});
      check($sformatf("vec%0d s_wdata", i), s_wdata[0], vecs[i].e_g ? M1_WDATA : M0_WDATA);
      check($sformatf("vec%0d grant", i), {31'd0, grant[0]}, {31'd0, vecs[i].e_g});
      check($sformatf("vec%0d busy", i), {31'd0, busy[0]}, {31'd0, vecs[i].e_busy});
      check($sformatf("vec%0d m0_ready", i), {31'd0, m0_ready[0]}, {31'd0, vecs[i].e_r0});
      check($sformatf("vec%0d m1_ready", i), {31'd0, m1_ready[0]}, {31'd0, vecs[i].e_r1});
      check($sformatf("vec%0d m0_rdata", i), m0_rdata[0], vecs[i].e_d0);
      check($sformatf("vec%0d m1_rdata", i), m1_rdata[0], vecs[i].e_d1);
      check($sformatf("vec%0d timeout_err", i), {31'd0, timeout_err[0]}, {31'd0, vecs[i].e_to});
    end

    // Timeout: slave silent, forced completion after 8 busy cycles
    s_ready = 0; m0_valid = 0; m1_valid = 1; m1_addr = 32'h300;
    step();
    check("to grant", {31'd0, grant[0]}, 1);
    check("to s_valid", {31'd0, s_valid[0]}, 1);
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("to wait%0d ready/err", k), {30'd0, m1_ready[0], timeout_err[0]}, 0);
      check($sformatf("to wait%0d busy", k), {31'd0, busy[0]}, 1);
    end
    step();
    check("to m1_ready", {31'd0, m1_ready[0]}, 1);
    check("to timeout_err", {31'd0, timeout_err[0]}, 1);
    check("to m1_rdata", m1_rdata[0], 32'hDEAD_BEEF);
    check("to s_valid low", {31'd0, s_valid[0]}, 0);
    check("to m0_ready", {31'd0, m0_ready[0]}, 0);
    m1_valid = 0;
    step();
    check("to pulse end", {30'd0, m1_ready[0], timeout_err[0]}, 0);
    check("to idle", {31'd0, busy[0]}, 0);

    // Timeout race: s_ready on the terminal-count cycle
    m0_valid = 1; m0_addr = 32'h400; m0_wstrb = 0;
    step();
    for (int k = 1; k < 8; k++) step();
    check("race still busy", {31'd0, busy[0]}, 1);
    s_ready = 1; s_rdata = 32'h7777_1111;
    step();
    check("race m0_ready", {31'd0, m0_ready[0]}, 1);
    check("race m0_rdata", m0_rdata[0], 32'h7777_1111);
    check("race timeout_err", {31'd0, timeout_err[0]}, 0);
    m0_valid = 0; s_ready = 0;
    step();

    // Reset mid-transaction, then a clean m1 request
    m0_valid = 1; m0_addr = 32'h500;
    step();
    check("rmid busy before", {31'd0, busy[0]}, 1);
    reset = 1;
    step();
    reset = 0; m0_valid = 0;
    check("rmid s_valid", {31'd0, s_valid[0]}, 0);
    check("rmid busy", {31'd0, busy[0]}, 0);
    check("rmid m0_ready", {31'd0, m0_ready[0]}, 0);
    check("rmid m0_rdata", m0_rdata[0], 0);
    step();
    check("rmid no late ready", {30'd0, m1_ready[0], m0_ready[0]}, 0);
    m1_valid = 1; m1_addr = 32'h600;
    step();
    check("rmid m1 grant", {31'd0, grant[0]}, 1);
    check("rmid m1 s_addr", s_addr[0], 32'h600);
    s_ready = 1; s_rdata = 32'h6666_0000;
    step();
    check("rmid m1_ready", {31'd0, m1_ready[0]}, 1);
    check("rmid m1_rdata", m1_rdata[0], 32'h6666_0000);
    m1_valid = 0; s_ready = 0;
    step();

    // Fixed priority: m0 back-to-back wins every tie on instance 1
    reset = 1;
    step();
    reset = 0;
    m0_valid = 1; m0_addr = 32'h700; m1_valid = 1; m1_addr = 32'h800;
    step();
    check("fp1 grant", {31'd0, grant[1]}, 0);
    check("fp1 s_addr", s_addr[1], 32'h700);
    s_ready = 1; s_rdata = 32'h1;
    step();
    check("fp1 m0_ready", {31'd0, m0_ready[1]}, 1);
    check("fp1 m0_rdata", m0_rdata[1], 32'h1);
    s_ready = 0; m0_addr = 32'h704;
    step();
    check("fp done->idle", {31'd0, busy[1]}, 0);
    step();
    check("fp2 grant", {31'd0, grant[1]}, 0);
    check("fp2 s_addr", s_addr[1], 32'h704);
    check("rr2 grant", {31'd0, grant[0]}, 1);
    check("rr2 s_addr", s_addr[0], 32'h800);
    s_ready = 1; s_rdata = 32'h2;
    step();
    check("fp2 m0_rdata", m0_rdata[1], 32'h2);
    check("fp2 m1_ready", {31'd0, m1_ready[1]}, 0);
    check("rr2 m1_rdata", m1_rdata[0], 32'h2);
    m0_valid = 0; s_ready = 0;
    step();
    step();
    check("fp3 grant", {31'd0, grant[1]}, 1);
    check("fp3 s_addr", s_addr[1], 32'h800);
    s_ready = 1; s_rdata = 32'h3;
    step();
    check("fp3 m1_ready", {31'd0, m1_ready[1]}, 1);
    check("fp3 m1_rdata", m1_rdata[1], 32'h3);
    m1_valid = 0; s_ready = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
